// File: rtl/bnn_pkg.sv
// Shared constants and types for the bnn output-activation argmax reader.
package bnn_pkg;
  localparam int unsigned ADDR_W      = 11;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned OUT_BASE    = 1024;
  localparam int unsigned CLASS_W     = $clog2(NUM_CLASSES);

  typedef logic signed [DATA_W-1:0] act_t;
  typedef logic [CLASS_W-1:0]       class_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESULT} argmax_state_t;
endpackage

// File: rtl/bnn_rd_tag_pipe.sv
// Delay line of {valid, class index} that tracks each activation read
// until its data returns from the bnn read port.
module bnn_rd_tag_pipe
  import bnn_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid,
  input  class_t in_idx,
  output logic   out_valid,
  output class_t out_idx
);

  for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
    logic   valid_d;
    logic   valid_q;
    class_t idx_d;
    class_t idx_q;

    if (gi == 0) begin : g_head
      assign valid_d = in_valid;
      assign idx_d   = in_idx;
    end else begin : g_tail
      assign valid_d = g_stage[gi-1].valid_q;
      assign idx_d   = g_stage[gi-1].idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        idx_q   <= '0;
      end else begin
        valid_q <= valid_d;
        idx_q   <= idx_d;
      end
    end
  end

  assign out_valid = g_stage[RD_LATENCY-1].valid_q;
  assign out_idx   = g_stage[RD_LATENCY-1].idx_q;

endmodule

// File: rtl/bnn_argmax.sv
// Scans the bnn output activations after each done rising edge and returns
// the signed argmax (lowest index wins ties) on a valid/ready interface.
module bnn_argmax
  import bnn_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bnn_done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [3:0]        class_idx,
  output logic [DATA_W-1:0] max_score,
  output logic              busy,
  output logic              overrun
);

  if (OUT_BASE + NUM_CLASSES - 1 >= (1 << ADDR_W)) begin : g_addr_chk
    $error("bnn_argmax: last class address does not fit in ADDR_W");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_lat_chk
    $error("bnn_argmax: RD_LATENCY must be 1..4");
  end
  if (CLASS_W > 4) begin : g_cls_chk
    $error("bnn_argmax: class index does not fit in 4 bits");
  end

  argmax_state_t     state_q, state_d;
  logic              done_q, done_d;
  logic              armed_q, armed_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              issue_valid_q, issue_valid_d;
  class_t            issue_idx_q, issue_idx_d;
  act_t              max_q, max_d;
  class_t            max_idx_q, max_idx_d;
  logic              last_q, last_d;
  logic              result_valid_q, result_valid_d;
  logic [3:0]        class_idx_q, class_idx_d;
  act_t              max_score_q, max_score_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;

  logic   trigger;
  logic   tag_valid;
  class_t tag_idx;
  act_t   rd_act;

  // armed_q blocks a trigger on the first cycle after reset release so a
  // done level already high at release is not mistaken for an edge.
  assign trigger = bnn_done & ~done_q & armed_q;
  assign rd_act  = act_t'(rd_data);

  bnn_rd_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (issue_valid_q),
    .in_idx   (issue_idx_q),
    .out_valid(tag_valid),
    .out_idx  (tag_idx)
  );

  always_comb begin
    state_d        = state_q;
    done_d         = bnn_done;
    armed_d        = 1'b1;
    rd_addr_d      = rd_addr_q;
    issue_valid_d  = issue_valid_q;
    issue_idx_d    = issue_idx_q;
    max_d          = max_q;
    max_idx_d      = max_idx_q;
    last_d         = last_q;
    result_valid_d = result_valid_q;
    class_idx_d    = class_idx_q;
    max_score_d    = max_score_q;
    busy_d         = busy_q;
    overrun_d      = overrun_q;

    if (tag_valid) begin
      if (tag_idx == '0 || rd_act > max_q) begin
        max_d     = rd_act;
        max_idx_d = tag_idx;
      end
      if (tag_idx == class_t'(NUM_CLASSES - 1)) begin
        last_d = 1'b1;
      end
    end

    if (trigger && state_q != IDLE) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d       = ISSUE;
          busy_d        = 1'b1;
          rd_addr_d     = ADDR_W'(OUT_BASE);
          issue_valid_d = 1'b1;
          issue_idx_d   = '0;
          last_d        = 1'b0;
        end
      end
      ISSUE: begin
        if (issue_idx_q == class_t'(NUM_CLASSES - 1)) begin
          state_d       = DRAIN;
          rd_addr_d     = '0;
          issue_valid_d = 1'b0;
          issue_idx_d   = '0;
        end else begin
          rd_addr_d   = rd_addr_q + ADDR_W'(1);
          issue_idx_d = issue_idx_q + class_t'(1);
        end
      end
      DRAIN: begin
        if (last_q) begin
          state_d        = RESULT;
          result_valid_d = 1'b1;
          class_idx_d    = 4'(max_idx_q);
          max_score_d    = max_q;
        end
      end
      RESULT: begin
        if (result_ready) begin
          state_d        = IDLE;
          result_valid_d = 1'b0;
          busy_d         = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      done_q         <= 1'b0;
      armed_q        <= 1'b0;
      rd_addr_q      <= '0;
      issue_valid_q  <= 1'b0;
      issue_idx_q    <= '0;
      max_q          <= '0;
      max_idx_q      <= '0;
      last_q         <= 1'b0;
      result_valid_q <= 1'b0;
      class_idx_q    <= '0;
      max_score_q    <= '0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      done_q         <= done_d;
      armed_q        <= armed_d;
      rd_addr_q      <= rd_addr_d;
      issue_valid_q  <= issue_valid_d;
      issue_idx_q    <= issue_idx_d;
      max_q          <= max_d;
      max_idx_q      <= max_idx_d;
      last_q         <= last_d;
      result_valid_q <= result_valid_d;
      class_idx_q    <= class_idx_d;
      max_score_q    <= max_score_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
    end
  end

  assign rd_addr      = rd_addr_q;
  assign result_valid = result_valid_q;
  assign class_idx    = class_idx_q;
  assign max_score    = max_score_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_bnn_argmax.sv
// Scoreboard bench for bnn_argmax: one instance at read latency 1, one at 3,
// each fed by a delayed activation memory model.
module tb_bnn_argmax;
  import bnn_pkg::*;

  localparam int NC = NUM_CLASSES;

  typedef struct {
    int idx;
    int score;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int scores [NC];
  int n_checks = 0;
  int n_errors = 0;

  exp_t sb1 [$];
  exp_t sb3 [$];

  logic              done1 = 1'b0, rdy1 = 1'b1;
  logic [ADDR_W-1:0] rd_addr1;
  logic [DATA_W-1:0] rd_data1, score1;
  logic              res_v1, busy1, ovr1;
  logic [3:0]        class_idx1;

  logic              done3 = 1'b0, rdy3 = 1'b1;
  logic [ADDR_W-1:0] rd_addr3;
  logic [DATA_W-1:0] rd_data3, score3;
  logic              res_v3, busy3, ovr3;
  logic [3:0]        class_idx3;

  bnn_argmax #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bnn_done(done1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .result_valid(res_v1), .result_ready(rdy1), .class_idx(class_idx1),
    .max_score(score1), .busy(busy1), .overrun(ovr1)
  );

  bnn_argmax #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bnn_done(done3), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .result_valid(res_v3), .result_ready(rdy3), .class_idx(class_idx3),
    .max_score(score3), .busy(busy3), .overrun(ovr3)
  );

  function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    int off;
    off = int'(a) - int'(OUT_BASE);
    if (off >= 0 && off < NC) return 8'(scores[off]);
    return 8'h00;
  endfunction

  logic [DATA_W-1:0] m1_q;
  logic [DATA_W-1:0] m3_q [3];
  always @(posedge clk) begin
    m1_q    <= mem_rd(rd_addr1);
    m3_q[0] <= mem_rd(rd_addr3);
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign rd_data1 = m1_q;
  assign rd_data3 = m3_q[2];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t expect_for(input int lat, input int now);
    exp_t e;
    e.idx   = 0;
    e.score = scores[0];
    for (int i = 1; i < NC; i++) begin
      if (scores[i] > e.score) begin
        e.idx   = i;
        e.score = scores[i];
      end
    end
    e.cyc = now + 1 + NC + lat + 1;
    return e;
  endfunction

  task automatic set_scores(input int s0, input int s1, input int s2, input int s3, input int s4,
                            input int s5, input int s6, input int s7, input int s8, input int s9);
    scores[0] = s0; scores[1] = s1; scores[2] = s2; scores[3] = s3; scores[4] = s4;
    scores[5] = s5; scores[6] = s6; scores[7] = s7; scores[8] = s8; scores[9] = s9;
  endtask

  // Raise done on the selected DUT; push an expectation when a scan should follow.
  task automatic start(input int which, input bit push_exp);
    @(negedge clk);
    if (which == 1) begin
      done1 = 1'b1;
      if (push_exp) sb1.push_back(expect_for(1, cyc));
    end else begin
      done3 = 1'b1;
      if (push_exp) sb3.push_back(expect_for(3, cyc));
    end
  endtask

  task automatic wait_done(input int which);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (which == 1 && !busy1 && !res_v1 && sb1.size() == 0) begin ok = 1'b1; break; end
      if (which == 3 && !busy3 && !res_v3 && sb3.size() == 0) begin ok = 1'b1; break; end
    end
    check("scan_timeout", int'(ok), 1);
  endtask

  logic prev_v1 = 1'b0, prev_v3 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      prev_v1 = 1'b0;
    end else begin
      if (res_v1 && !prev_v1) begin
        if (sb1.size() == 0) check("dut1_unexpected_result", 1, 0);
        else check("dut1_valid_rise_cycle", cyc, sb1[0].cyc);
      end
      if (res_v1 && rdy1 && sb1.size() != 0) begin
        e = sb1.pop_front();
        check("dut1_class_idx", int'(class_idx1), e.idx);
        check("dut1_max_score", int'($signed(score1)), e.score);
        $display("dut1 result: class_idx=%0d max_score=%0d cycle=%0d", class_idx1, $signed(score1), cyc);
      end
      prev_v1 = res_v1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      prev_v3 = 1'b0;
    end else begin
      if (res_v3 && !prev_v3) begin
        if (sb3.size() == 0) check("dut3_unexpected_result", 1, 0);
        else check("dut3_valid_rise_cycle", cyc, sb3[0].cyc);
      end
      if (res_v3 && rdy3 && sb3.size() != 0) begin
        e = sb3.pop_front();
        check("dut3_class_idx", int'(class_idx3), e.idx);
        check("dut3_max_score", int'($signed(score3)), e.score);
        $display("dut3 result: class_idx=%0d max_score=%0d cycle=%0d", class_idx3, $signed(score3), cyc);
      end
      prev_v3 = res_v3;
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_rd_addr"}, int'(rd_addr1), 0);
    check({tag, "_valid"}, int'(res_v1), 0);
    check({tag, "_class_idx"}, int'(class_idx1), 0);
    check({tag, "_max_score"}, int'(score1), 0);
    check({tag, "_busy"}, int'(busy1), 0);
    check({tag, "_overrun"}, int'(ovr1), 0);
  endtask

  initial begin
    set_scores(-10, 4, 37, -2, 0, 15, 37, -50, 8, 1);
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic scan with a tie at the maximum; address sequence checked too.
    start(1, 1'b1);
    @(negedge clk);
    check("first_addr", int'(rd_addr1), OUT_BASE);
    check("busy_after_trigger", int'(busy1), 1);
    repeat (9) @(negedge clk);
    check("last_addr", int'(rd_addr1), OUT_BASE + NC - 1);
    @(negedge clk);
    check("drain_addr", int'(rd_addr1), 0);
    wait_done(1);
    check("valid_one_cycle", int'(res_v1), 0);
    done1 = 1'b0;

    // All minimum values: first index wins.
    set_scores(-128, -128, -128, -128, -128, -128, -128, -128, -128, -128);
    start(1, 1'b1);
    wait_done(1);
    done1 = 1'b0;

    // Backpressure with the only positive value at the last index.
    set_scores(-1, -1, -1, -1, -1, -1, -1, -1, -1, 127);
    rdy1 = 1'b0;
    start(1, 1'b1);
    for (int k = 0; k < 40 && !res_v1; k++) @(negedge clk);
    check("bp_valid_seen", int'(res_v1), 1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_valid_hold", int'(res_v1), 1);
      check("bp_idx_hold", int'(class_idx1), 9);
      check("bp_score_hold", int'($signed(score1)), 127);
      check("bp_busy_hold", int'(busy1), 1);
    end
    rdy1 = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", int'(res_v1), 0);
    check("bp_busy_drop", int'(busy1), 0);
    repeat (5) @(negedge clk);
    check("held_done_no_rescan", int'(busy1), 0);
    check("bp_overrun_clear", int'(ovr1), 0);

    // Second done edge while scanning sets overrun but does not disturb the scan.
    set_scores(-10, 4, 37, -2, 0, 15, 37, -50, 8, 1);
    done1 = 1'b0;
    start(1, 1'b1);
    repeat (2) @(negedge clk);
    done1 = 1'b0;
    @(negedge clk);
    done1 = 1'b1;
    @(negedge clk);
    check("overrun_set", int'(ovr1), 1);
    wait_done(1);
    check("overrun_sticky", int'(ovr1), 1);
    set_scores(5, 6, 7, 100, -100, 3, 2, 1, 0, 99);
    done1 = 1'b0;
    start(1, 1'b1);
    wait_done(1);
    check("overrun_still_set", int'(ovr1), 1);
    done1 = 1'b0;

    // Reset in the middle of the address sweep.
    set_scores(3, -3, 12, 44, 44, -7, 0, 43, -128, 20);
    start(1, 1'b1);
    repeat (5) @(negedge clk);
    check("mid_scan_addr", int'(rd_addr1), OUT_BASE + 4);
    rst_n = 1'b0;
    #1;
    check_reset_state("midscan_reset");
    sb1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_trigger_at_release", int'(busy1), 0);
    done1 = 1'b0;
    start(1, 1'b1);
    @(negedge clk);
    check("rescan_first_addr", int'(rd_addr1), OUT_BASE);
    wait_done(1);
    done1 = 1'b0;

    // Longer read latency on the second instance.
    set_scores(1, 2, 3, 4, 5, 6, 7, 8, 9, -1);
    start(3, 1'b1);
    wait_done(3);
    done3 = 1'b0;

    check("sb1_drained", sb1.size(), 0);
    check("sb3_drained", sb3.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
